// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and the vector address helper.
package int_ctrl_pkg;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [2:0]  id);
    return base + stride * {29'b0, id};
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-side port bundle: memory-mapped register access plus the interrupt
// request/acknowledge pair toward the controller.
interface int_ctrl_if;
  // Handshake: int_req stays high until the CPU pulses int_ack for one cycle
  // (taken) or the request is withdrawn; eret pulses once at handler exit.
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_req;
  logic [31:0] int_vector;
  logic        int_ack;
  logic        eret;

  modport master (
    output we, addr, wdata, int_ack, eret,
    input  rdata, int_req, int_vector
  );

  modport slave (
    input  we, addr, wdata, int_ack, eret,
    output rdata, int_req, int_vector
  );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; any flags a non-empty vector.
module int_ctrl_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [2:0]   id
);

  always_comb begin
    any = 1'b0;
    id  = 3'd0;
    // Scan downward so the last hit (the lowest index) is what remains.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any = 1'b1;
        id  = i[2:0];
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, fixed-priority arbitration,
// and a vectored request FSM that can be bypassed for polling.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  int_ctrl_if.slave        bus,
  output state_t           state_dbg
);

  logic [N_SRC-1:0] mask, pending, irq_q;
  logic [N_SRC-1:0] eligible, rise, w1c, ack_clr;
  logic             gie, poll;
  logic             act_valid;
  logic [2:0]       act_id;
  logic             elig_any;
  logic [2:0]       elig_id;
  logic             latch_id, clr_id, take;
  logic             unused_wdata;
  state_t           state, state_nxt;

  assign eligible     = pending & mask;
  assign rise         = irq & ~irq_q;
  assign w1c          = (bus.we && bus.addr == ADDR_PENDING) ? bus.wdata[N_SRC-1:0] : '0;
  assign ack_clr      = take ? ({{(N_SRC-1){1'b0}}, 1'b1} << act_id) : '0;
  assign unused_wdata = ^bus.wdata;

  int_ctrl_prio_enc #(.N(N_SRC)) u_prio (
    .vec (eligible),
    .any (elig_any),
    .id  (elig_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The winner is frozen at IDLE->REQ, so later arrivals never pre-empt it.
  always_comb begin
    state_nxt = state;
    latch_id  = 1'b0;
    clr_id    = 1'b0;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gie && !poll && elig_any) begin
          state_nxt = ST_REQ;
          latch_id  = 1'b1;
        end
      end
      ST_REQ: begin
        if (!gie || poll) begin
          state_nxt = ST_IDLE;
          clr_id    = 1'b1;
        end else if (bus.int_ack) begin
          state_nxt = ST_SERVICE;
          take      = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (bus.eret) begin
          state_nxt = ST_IDLE;
          clr_id    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask      <= '0;
      pending   <= '0;
      irq_q     <= '0;
      gie       <= 1'b0;
      poll      <= 1'b0;
      act_valid <= 1'b0;
      act_id    <= 3'd0;
    end else begin
      irq_q   <= irq;
      // A new edge overrides any clear landing on the same bit.
      pending <= (pending & ~w1c & ~ack_clr) | rise;
      if (bus.we && bus.addr == ADDR_MASK) mask <= bus.wdata[N_SRC-1:0];
      if (bus.we && bus.addr == ADDR_CTRL) begin
        gie  <= bus.wdata[0];
        poll <= bus.wdata[1];
      end
      if (latch_id)    act_id    <= elig_id;
      else if (clr_id) act_id    <= 3'd0;
      if (take)        act_valid <= 1'b1;
      else if (clr_id) act_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_MASK:    bus.rdata[N_SRC-1:0] = mask;
      ADDR_PENDING: bus.rdata[N_SRC-1:0] = pending;
      ADDR_ACTIVE:  bus.rdata[3:0]       = {act_valid, act_id};
      ADDR_CTRL:    bus.rdata[1:0]       = {poll, gie};
      default:      bus.rdata            = '0;
    endcase
  end

  assign bus.int_req    = (state == ST_REQ);
  assign bus.int_vector = vec_addr(VEC_BASE, VEC_STRIDE, act_id);
  assign state_dbg      = state;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed and randomized checks of int_ctrl against a cycle-level model.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic       tb_clk = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] irq    = '0;
  state_t     state_dbg;
  int         checks = 0;
  int         errors = 0;

  int_ctrl_if bus_if ();

  int_ctrl #(.N_SRC(4), .VEC_BASE(32'h180), .VEC_STRIDE(32'h10)) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .irq       (irq),
    .bus       (bus_if.slave),
    .state_dbg (state_dbg)
  );

  always #5 tb_clk = ~tb_clk;

  // Reference model: mode 0 = idle, 1 = requesting, 2 = in handler.
  bit [3:0]    m_mask, m_pend, m_irq_q;
  bit          m_gie, m_poll, m_valid;
  int          m_mode, m_id;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_irq_q = '0;
    m_gie = 0; m_poll = 0; m_valid = 0;
    m_mode = 0; m_id = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_mask};
      2'd1:    return {28'b0, m_pend};
      2'd2:    return 32'(m_valid) * 8 + 32'(m_id);
      default: return {30'b0, m_poll, m_gie};
    endcase
  endfunction

  task automatic model_step();
    bit [3:0] elig, nxt;
    int first;
    elig  = m_pend & m_mask;
    first = -1;
    for (int i = 0; i < 4; i++) if (elig[i] && first < 0) first = i;
    nxt = m_pend;
    if (m_mode == 0) begin
      if (m_gie && !m_poll && first >= 0) begin
        m_mode = 1; m_id = first;
        exp_q.push_back(32'h180 + 32'(first) * 16);
      end
    end else if (m_mode == 1) begin
      if (!m_gie || m_poll) begin
        m_mode = 0; m_id = 0;
        if (exp_q.size() > 0) exp_q.delete(0);
      end else if (bus_if.int_ack) begin
        m_mode = 2; m_valid = 1; nxt[m_id] = 1'b0;
      end
    end else if (bus_if.eret) begin
      m_mode = 0; m_valid = 0; m_id = 0;
    end
    if (bus_if.we) begin
      case (bus_if.addr)
        2'd0: m_mask = bus_if.wdata[3:0];
        2'd1: nxt = nxt & ~bus_if.wdata[3:0];
        2'd3: begin m_gie = bus_if.wdata[0]; m_poll = bus_if.wdata[1]; end
        default: ;
      endcase
    end
    nxt     = nxt | (irq & ~m_irq_q);
    m_pend  = nxt;
    m_irq_q = irq;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: advance model with current inputs, then check request outputs.
  task automatic tick();
    bit          took;
    logic [31:0] taken, want;
    took  = (m_mode == 1) && m_gie && !m_poll && (bus_if.int_ack === 1'b1);
    taken = bus_if.int_vector;
    model_step();
    @(posedge tb_clk);
    #1;
    if (took) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("taken_vector", taken, want);
    end
    chk("int_req", {31'b0, bus_if.int_req}, {31'b0, m_mode == 1});
    if (m_mode == 1) chk("int_vector", bus_if.int_vector, 32'h180 + 32'(m_id) * 16);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    tick();
    bus_if.we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus_if.addr = a;
    #1;
    chk(tag, bus_if.rdata, exp);
  endtask

  task automatic pulse_ack();
    bus_if.int_ack = 1'b1; tick(); bus_if.int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    bus_if.eret = 1'b1; tick(); bus_if.eret = 1'b0;
  endtask

  initial begin
    bus_if.we = 0; bus_if.addr = '0; bus_if.wdata = '0;
    bus_if.int_ack = 0; bus_if.eret = 0;
    model_reset();
    repeat (3) @(posedge tb_clk);
    #1;
    chk("reset_int_req", {31'b0, bus_if.int_req}, 32'd0);
    chk("reset_vector", bus_if.int_vector, 32'h180);
    rst = 1'b0;

    // Single source: two-cycle latency, service and return.
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    irq = 4'b0100; tick(); irq = 4'b0000;
    chk("t2_no_req_yet", {31'b0, bus_if.int_req}, 32'd0);
    tick();
    chk("t2_req", {31'b0, bus_if.int_req}, 32'd1);
    chk("t2_vector", bus_if.int_vector, 32'h1A0);
    pulse_ack();
    rd_chk("t2_pending", 2'd1, 32'h0);
    rd_chk("t2_active", 2'd2, 32'hA);
    pulse_eret();
    rd_chk("t2_active_cleared", 2'd2, 32'h0);

    // Simultaneous edges: lower index first, then the other.
    irq = 4'b1010; tick(); irq = 4'b0000; tick();
    chk("t3_first_vector", bus_if.int_vector, 32'h190);
    pulse_ack();
    pulse_eret();
    tick();
    chk("t3_second_req", {31'b0, bus_if.int_req}, 32'd1);
    chk("t3_second_vector", bus_if.int_vector, 32'h1B0);
    pulse_ack();
    pulse_eret();

    // Polling mode.
    wr(2'd3, 32'h3);
    irq = 4'b0001; tick(); irq = 4'b0000; tick();
    rd_chk("t4_pending", 2'd1, 32'h1);
    chk("t4_no_req", {31'b0, bus_if.int_req}, 32'd0);
    wr(2'd1, 32'h1);
    rd_chk("t4_pending_cleared", 2'd1, 32'h0);
    wr(2'd3, 32'h1);

    // W1C racing a new edge on the same bit.
    wr(2'd0, 32'h0);
    irq = 4'b0010; tick(); irq = 4'b0000; tick();
    irq = 4'b0010; wr(2'd1, 32'h2); irq = 4'b0000;
    rd_chk("t5_set_wins", 2'd1, 32'h2);
    wr(2'd1, 32'h2);
    rd_chk("t5_cleared", 2'd1, 32'h0);

    // Masked source, then unmask.
    wr(2'd0, 32'h1);
    irq = 4'b1000; tick(); irq = 4'b0000; tick();
    chk("t6_masked_no_req", {31'b0, bus_if.int_req}, 32'd0);
    rd_chk("t6_pending", 2'd1, 32'h8);
    wr(2'd0, 32'h9);
    tick();
    chk("t6_req", {31'b0, bus_if.int_req}, 32'd1);
    chk("t6_vector", bus_if.int_vector, 32'h1B0);

    // Asynchronous reset while requesting.
    rst = 1'b1;
    #1;
    model_reset();
    chk("t1_rst_int_req", {31'b0, bus_if.int_req}, 32'd0);
    chk("t1_rst_vector", bus_if.int_vector, 32'h180);
    for (int a = 0; a < 4; a++) rd_chk("t1_rst_rdata", 2'(a), 32'h0);
    @(posedge tb_clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model.
    wr(2'd0, 32'($urandom_range(0, 15)));
    wr(2'd3, 32'h1);
    for (int n = 0; n < 600; n++) begin
      irq            = 4'($urandom_range(0, 15));
      bus_if.int_ack = ($urandom_range(0, 3) == 0);
      bus_if.eret    = ($urandom_range(0, 4) == 0);
      bus_if.we      = ($urandom_range(0, 7) == 0);
      bus_if.addr    = 2'($urandom_range(0, 3));
      bus_if.wdata   = $urandom;
      if (bus_if.addr == 2'd3 && $urandom_range(0, 5) != 0) bus_if.wdata = 32'h1;
      tick();
      bus_if.we = 1'b0;
      bus_if.int_ack = 1'b0;
      bus_if.eret = 1'b0;
      begin
        logic [1:0] ra;
        ra = 2'($urandom_range(0, 3));
        rd_chk("rand_rdata", ra, m_reg(ra));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
